// File: rtl/nbody_step_sequencer.sv
// Per-frame three-body scheduler: walks pairs AB/AC/BC on a shared force unit,
// integrates each body, then commits all six coordinates to the renderer at once.
module nbody_step_sequencer #(
  parameter int COORD_W = 10,
  parameter int VEL_W   = 10,
  parameter int OVR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic                 run_en,
  output logic                 f_req,
  output logic [1:0]           f_pair,
  output logic [COORD_W:0]     f_dist,
  input  logic                 f_ack,
  input  logic [1:0]           f_mag,
  output logic [3*COORD_W-1:0] pos_x,
  output logic [3*COORD_W-1:0] pos_y,
  output logic                 busy,
  output logic                 done,
  output logic [OVR_W-1:0]     overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PAIR0  = 3'd1,
    PAIR1  = 3'd2,
    PAIR2  = 3'd3,
    INT0   = 3'd4,
    INT1   = 3'd5,
    INT2   = 3'd6,
    COMMIT = 3'd7
  } state_t;

  localparam logic [3*COORD_W-1:0] RST_PX = {COORD_W'(200), COORD_W'(420), COORD_W'(300)};
  localparam logic [3*COORD_W-1:0] RST_PY = {COORD_W'(20), COORD_W'(300), COORD_W'(150)};
  localparam logic signed [VEL_W:0] VMAX = (VEL_W+1)'((1 << (VEL_W-1)) - 1);
  localparam logic signed [VEL_W:0] VMIN = -VMAX;

  state_t                 state_q;
  logic                   vsync_q;
  logic                   f_req_q;
  logic [1:0]             f_pair_q;
  logic                   busy_q;
  logic                   done_q;
  logic [OVR_W-1:0]       ovr_q;
  logic [3*COORD_W-1:0]   pos_x_q;
  logic [3*COORD_W-1:0]   pos_y_q;
  logic [3*COORD_W-1:0]   wx_all;
  logic [3*COORD_W-1:0]   wy_all;

  logic                   tick;
  logic                   acc_clr;
  logic                   acc_en;
  logic [1:0]             idx_i;
  logic [1:0]             idx_j;
  logic signed [COORD_W-1:0] xi, xj, yi, yj;
  logic signed [COORD_W:0]   dx, dy;
  logic [COORD_W:0]       adx, ady;
  logic signed [3:0]      mag_s, stx, sty;

  // Saturate symmetrically; -2^(VEL_W-1) is never produced.
  function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] v,
                                                      input logic signed [3:0] a);
    logic signed [VEL_W:0] s;
    s = $signed({v[VEL_W-1], v}) + (VEL_W+1)'(a);
    if (s > VMAX)      sat_add = VMAX[VEL_W-1:0];
    else if (s < VMIN) sat_add = VMIN[VEL_W-1:0];
    else               sat_add = s[VEL_W-1:0];
  endfunction

  assign tick    = vsync & ~vsync_q;
  assign acc_clr = (state_q == IDLE) & tick & run_en;
  assign acc_en  = f_req_q & f_ack;
  assign idx_i   = (f_pair_q == 2'd2) ? 2'd1 : 2'd0;
  assign idx_j   = (f_pair_q == 2'd0) ? 2'd1 : 2'd2;

  always_comb begin
    xi    = (f_pair_q == 2'd2) ? wx_all[COORD_W +: COORD_W]   : wx_all[0 +: COORD_W];
    xj    = (f_pair_q == 2'd0) ? wx_all[COORD_W +: COORD_W]   : wx_all[2*COORD_W +: COORD_W];
    yi    = (f_pair_q == 2'd2) ? wy_all[COORD_W +: COORD_W]   : wy_all[0 +: COORD_W];
    yj    = (f_pair_q == 2'd0) ? wy_all[COORD_W +: COORD_W]   : wy_all[2*COORD_W +: COORD_W];
    dx    = {xj[COORD_W-1], xj} - {xi[COORD_W-1], xi};
    dy    = {yj[COORD_W-1], yj} - {yi[COORD_W-1], yi};
    adx   = dx[COORD_W] ? -dx : dx;
    ady   = dy[COORD_W] ? -dy : dy;
    mag_s = {2'b00, f_mag};
    stx   = (dx > 0) ? mag_s : ((dx < 0) ? -mag_s : 4'sd0);
    sty   = (dy > 0) ? mag_s : ((dy < 0) ? -mag_s : 4'sd0);
  end

  assign f_dist = adx + ady;

  for (genvar gi = 0; gi < 3; gi++) begin : g_body
    localparam logic [1:0] BODY   = 2'(gi);
    localparam logic [2:0] INT_ST = 3'(4 + gi);
    logic signed [COORD_W-1:0] px_q, py_q;
    logic signed [VEL_W-1:0]   vx_q, vy_q, vx_d, vy_d;
    logic signed [3:0]         ax_q, ay_q, dax, day;
    logic                      is_i, is_j, int_en;

    assign is_i   = acc_en && (idx_i == BODY);
    assign is_j   = acc_en && (idx_j == BODY);
    assign dax    = is_i ? stx : (is_j ? -stx : 4'sd0);
    assign day    = is_i ? sty : (is_j ? -sty : 4'sd0);
    assign int_en = (state_q == INT_ST);
    assign vx_d   = sat_add(vx_q, ax_q);
    assign vy_d   = sat_add(vy_q, ay_q);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        px_q <= RST_PX[gi*COORD_W +: COORD_W];
        py_q <= RST_PY[gi*COORD_W +: COORD_W];
        vx_q <= '0;
        vy_q <= '0;
        ax_q <= '0;
        ay_q <= '0;
      end else begin
        if (acc_clr) begin
          ax_q <= '0;
          ay_q <= '0;
        end else begin
          ax_q <= ax_q + dax;
          ay_q <= ay_q + day;
        end
        // Position advances with the pre-update velocity.
        if (int_en) begin
          px_q <= px_q + COORD_W'(vx_q);
          py_q <= py_q + COORD_W'(vy_q);
          vx_q <= vx_d;
          vy_q <= vy_d;
        end
      end
    end

    assign wx_all[gi*COORD_W +: COORD_W] = px_q;
    assign wy_all[gi*COORD_W +: COORD_W] = py_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b1;
      f_req_q  <= 1'b0;
      f_pair_q <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= '0;
      pos_x_q  <= RST_PX;
      pos_y_q  <= RST_PY;
    end else begin
      vsync_q <= vsync;
      done_q  <= 1'b0;
      if (tick && busy_q && (ovr_q != {OVR_W{1'b1}}))
        ovr_q <= ovr_q + OVR_W'(1);
      case (state_q)
        IDLE: if (tick && run_en) begin
          state_q  <= PAIR0;
          f_req_q  <= 1'b1;
          f_pair_q <= 2'd0;
          busy_q   <= 1'b1;
        end
        PAIR0: if (f_ack) begin
          state_q  <= PAIR1;
          f_pair_q <= 2'd1;
        end
        PAIR1: if (f_ack) begin
          state_q  <= PAIR2;
          f_pair_q <= 2'd2;
        end
        PAIR2: if (f_ack) begin
          state_q <= INT0;
          f_req_q <= 1'b0;
        end
        INT0: state_q <= INT1;
        INT1: state_q <= INT2;
        INT2: state_q <= COMMIT;
        COMMIT: begin
          pos_x_q <= wx_all;
          pos_y_q <= wy_all;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_req   = f_req_q;
  assign f_pair  = f_pair_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Directed bench for nbody_step_sequencer: hand-computed frames, ack stalls,
// overrun, run_en gating, mid-frame reset and a long velocity-pumping run.
module tb_nbody_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        run_en = 1'b0;
  logic        f_ack = 1'b0;
  logic [1:0]  f_mag = 2'd0;
  logic        f_req;
  logic [1:0]  f_pair;
  logic [10:0] f_dist;
  logic [29:0] pos_x;
  logic [29:0] pos_y;
  logic        busy;
  logic        done;
  logic [7:0]  overrun;

  localparam logic [29:0] RST_PX = {10'd200, 10'd420, 10'd300};
  localparam logic [29:0] RST_PY = {10'd20, 10'd300, 10'd150};
  localparam logic [29:0] F2_PX  = {10'd202, 10'd418, 10'd300};
  localparam logic [29:0] F2_PY  = {10'd22, 10'd298, 10'd150};

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay [3];
  int mag_tab [3];
  int wcnt = 0;
  int dist_seen [3];
  int p1_cycles = 0;
  bit chk_p1 = 1'b0;

  nbody_step_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .run_en  (run_en),
    .f_req   (f_req),
    .f_pair  (f_pair),
    .f_dist  (f_dist),
    .f_ack   (f_ack),
    .f_mag   (f_mag),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Force unit model: acks after ack_delay[pair] cycles of f_req on that pair.
  always @(negedge clk) begin
    if (f_ack) wcnt = 0;
    if (f_req) begin
      f_mag = 2'(mag_tab[f_pair]);
      if (wcnt >= ack_delay[f_pair]) f_ack = 1'b1;
      else begin
        f_ack = 1'b0;
        wcnt++;
      end
    end else begin
      f_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise vsync, wait for done; lat = posedge index (tick edge = 1) where done is seen.
  task automatic run_frame(output int lat);
    lat = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (f_req) begin
        dist_seen[f_pair] = int'(f_dist);
        if (f_pair == 2'd1) begin
          p1_cycles++;
          if (chk_p1) check_eq("p1_dist_hold", f_dist, 230);
        end
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check_eq("frame_done_seen", lat != 0, 1);
    @(negedge clk);
    vsync = 1'b0;
  endtask

  function automatic int wrapc(input int p);
    int t;
    t = (p + 512) % 1024;
    if (t < 0) t += 1024;
    return t - 512;
  endfunction

  function automatic int clampv(input int v);
    if (v > 511) return 511;
    if (v < -511) return -511;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  initial begin
    int lat;
    int rq;
    int dn;
    int mx [3];
    int my [3];
    int mvx [3];
    int mvy [3];
    int m;
    int sx;
    int sy;
    logic [29:0] ex;
    logic [29:0] ey;

    ack_delay = '{0, 0, 0};
    mag_tab   = '{1, 1, 1};

    // Test 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pos_x", pos_x, RST_PX);
    check_eq("rst_pos_y", pos_y, RST_PY);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_f_req", f_req, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    run_en = 1'b1;

    // Test 2: two frames, immediate ack, magnitude 1
    run_frame(lat);
    check_eq("f1_latency", lat, 8);
    check_eq("f1_dist_ab", dist_seen[0], 270);
    check_eq("f1_dist_ac", dist_seen[1], 230);
    check_eq("f1_dist_bc", dist_seen[2], 500);
    check_eq("f1_pos_x", pos_x, RST_PX);
    check_eq("f1_pos_y", pos_y, RST_PY);
    run_frame(lat);
    check_eq("f2_latency", lat, 8);
    check_eq("f2_pos_x", pos_x, F2_PX);
    check_eq("f2_pos_y", pos_y, F2_PY);
    check_eq("f2_busy", busy, 0);

    // Test 3: ack stalled 5 cycles on pair AC
    do_reset();
    ack_delay[1] = 5;
    p1_cycles = 0;
    chk_p1 = 1'b1;
    run_frame(lat);
    chk_p1 = 1'b0;
    ack_delay[1] = 0;
    check_eq("stall_latency", lat, 13);
    check_eq("stall_p1_cycles", p1_cycles, 6);

    // Test 4: tick while waiting on ack, then overrun saturation
    do_reset();
    ack_delay[0] = 20;
    @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    dn = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check_eq("ovr_one_done", dn, 1);
    check_eq("ovr_count1", overrun, 1);
    check_eq("ovr_idle_busy", busy, 0);
    ack_delay[0] = 100000;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("ovr_sat_busy", busy, 1);
    check_eq("ovr_sat", overrun, 255);
    ack_delay[0] = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check_eq("ovr_sat_done", dn, 1);
    check_eq("ovr_sat_hold", overrun, 255);
    @(negedge clk);
    vsync = 1'b0;

    // Test 5: run_en=0 ignores ticks
    do_reset();
    run_en = 1'b0;
    rq = 0;
    dn = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      vsync = ((i % 8) < 4);
      @(posedge clk);
      #1;
      if (f_req) rq++;
      if (done) dn++;
    end
    check_eq("gate_no_req", rq, 0);
    check_eq("gate_no_done", dn, 0);
    check_eq("gate_overrun", overrun, 0);
    check_eq("gate_pos_x", pos_x, RST_PX);
    run_en = 1'b1;

    // Test 6: reset during INT1 aborts the frame
    do_reset();
    run_frame(lat);
    @(negedge clk);
    vsync = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_f_req", f_req, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_pos_x", pos_x, RST_PX);
    check_eq("abort_pos_y", pos_y, RST_PY);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check_eq("abort_no_done", dn, 0);
    @(negedge clk);
    vsync = 1'b0;
    run_frame(lat);
    check_eq("abort_vel_cleared_x", pos_x, RST_PX);
    check_eq("abort_vel_cleared_y", pos_y, RST_PY);

    // Test 7: AB-only force pumped along B's motion until velocity saturates
    do_reset();
    mag_tab = '{0, 0, 0};
    mx = '{300, 420, 200};
    my = '{150, 300, 20};
    mvx = '{0, 0, 0};
    mvy = '{0, 0, 0};
    for (int f = 0; f < 800; f++) begin
      sx = sgn(mx[1] - mx[0]);
      sy = sgn(my[1] - my[0]);
      m = ((mvx[1] == 0) || (-sx * mvx[1] > 0)) ? 3 : 0;
      mag_tab[0] = m;
      run_frame(lat);
      for (int b = 0; b < 2; b++) begin
        mx[b] = wrapc(mx[b] + mvx[b]);
        my[b] = wrapc(my[b] + mvy[b]);
      end
      mvx[0] = clampv(mvx[0] + m * sx);
      mvy[0] = clampv(mvy[0] + m * sy);
      mvx[1] = clampv(mvx[1] - m * sx);
      mvy[1] = clampv(mvy[1] - m * sy);
      if ((f % 25) == 24) begin
        ex = {10'(mx[2]), 10'(mx[1]), 10'(mx[0])};
        ey = {10'(my[2]), 10'(my[1]), 10'(my[0])};
        check_eq("pump_pos_x", pos_x, ex);
        check_eq("pump_pos_y", pos_y, ey);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
